// File: rtl/mux_pkg.sv
// Shared constants for the registered round-robin / fixed-select mux.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search starting at ptr, plus the ptr register itself.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [SELW-1:0] grant,
  output logic            grant_valid,
  output logic [SELW-1:0] ptr
);

  always_comb begin
    int   start;
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    start = (int'(ptr) < N) ? int'(ptr) : 0;
    for (int k = 0; k < N; k++) begin
      idx = start + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = SELW'(idx);
      end
    end
    grant_valid = |req;
  end

  // The pointer moves one past the winner so the winner becomes lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant) == N - 1) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N-to-1 channel mux with a single output register; fixed or round-robin select.
// Handshake: a word moves when valid and ready are both high on a rising edge.
module rr_mux_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [SELW-1:0]  arb_grant;
  logic             arb_valid;
  logic [SELW-1:0]  ptr;
  logic             fix_valid;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             space;
  logic             load;
  logic [WIDTH-1:0] grant_data;

  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (in_valid),
    .advance     (load && (mode == MODE_RR)),
    .grant       (arb_grant),
    .grant_valid (arb_valid),
    .ptr         (ptr)
  );

  // An out-of-range sel matches no channel, so it never grants.
  always_comb begin
    fix_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(sel) == i) fix_valid = in_valid[i];
    end
  end

  assign grant       = (mode == MODE_RR) ? arb_grant : sel;
  assign grant_valid = (mode == MODE_RR) ? arb_valid : fix_valid;
  assign space       = !out_valid || out_ready;
  assign load        = space && grant_valid;

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(grant) == i) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = rst_n && load;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: directed scenarios plus random traffic against a reference model.
module tb_rr_mux_reg;
  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mode = 1'b0;
  logic [SELW-1:0]   sel = '0;
  logic [N*WIDTH-1:0] in_data = '0;
  logic [N-1:0]      in_valid = '0;
  logic [N-1:0]      in_ready;
  logic [WIDTH-1:0]  out_data;
  logic [SELW-1:0]   out_ch;
  logic              out_valid;
  logic              out_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit               m_v;
  logic [WIDTH-1:0] m_d;
  int               m_c;
  int               m_ptr;
  logic [WIDTH-1:0] exp_q[$];

  rr_mux_reg #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_d = '0; m_c = 0; m_ptr = 0;
  endtask

  task automatic model_grant(output int g, output bit gv);
    int s;
    g = 0; gv = 0;
    if (mode == 1'b0) begin
      s = int'(sel);
      if (s < N && in_valid[s]) begin g = s; gv = 1; end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (in_valid[(m_ptr + k) % N]) begin g = (m_ptr + k) % N; gv = 1; end
      end
    end
  endtask

  function automatic logic [WIDTH-1:0] ch_data(input int i);
    return in_data[i*WIDTH +: WIDTH];
  endfunction

  task automatic set_ch(input int i, input logic [WIDTH-1:0] v);
    in_data[i*WIDTH +: WIDTH] = v;
  endtask

  // Inputs are already applied; check in_ready, clock once, check the register.
  task automatic run_cycle(input string tag);
    int g; bit gv; bit ld; logic [N-1:0] exp_rdy;
    #1;
    model_grant(g, gv);
    ld = (!m_v || out_ready) && gv;
    exp_rdy = '0;
    if (ld) exp_rdy[g] = 1'b1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (ld) begin
      m_v = 1; m_d = ch_data(g); m_c = g;
      if (mode) m_ptr = (g + 1) % N;
      exp_q.push_back(m_d);
    end else if (m_v && out_ready) begin
      m_v = 0;
    end
    #1;
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_v));
    if (m_v) begin
      check({tag, ".out_data"}, 64'(out_data), 64'(m_d));
      check({tag, ".out_ch"}, 64'(out_ch), 64'(m_c));
    end
  endtask

  task automatic drive(input logic m, input logic [SELW-1:0] s, input logic [N-1:0] v,
                       input logic ordy);
    mode = m; sel = s; in_valid = v; out_ready = ordy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] held_d;
    logic [SELW-1:0]  held_c;
    for (int i = 0; i < N; i++) set_ch(i, 32'hA5A5_0000 | WIDTH'(i));

    // reset with every channel requesting
    drive(1'b1, 3'd0, 4'b1111, 1'b1);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_data", 64'(out_data), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle("rst_first");
    check("rst_first.ch0", 64'(out_ch), 64'd0);

    // fixed select
    do_reset();
    drive(1'b0, 3'd2, 4'b1111, 1'b1);
    #1;
    check("fixed.in_ready", 64'(in_ready), 64'b0100);
    run_cycle("fixed");
    check("fixed.data_const", 64'(out_data), 64'hA5A5_0002);
    check("fixed.ch_const", 64'(out_ch), 64'd2);

    // round-robin fairness
    do_reset();
    drive(1'b1, 3'd0, 4'b1111, 1'b1);
    for (int k = 0; k < 8; k++) begin
      run_cycle("fair");
      check("fair.seq", 64'(out_ch), 64'(k % 4));
    end

    // skip and wrap: make ptr=3 then exercise
    do_reset();
    drive(1'b1, 3'd0, 4'b0100, 1'b1);
    run_cycle("wrap_setup");
    drive(1'b1, 3'd0, 4'b0010, 1'b1);
    run_cycle("wrap_a");
    check("wrap_a.ch", 64'(out_ch), 64'd1);
    drive(1'b1, 3'd0, 4'b1001, 1'b1);
    run_cycle("wrap_b");
    check("wrap_b.ch", 64'(out_ch), 64'd3);
    run_cycle("wrap_c");
    check("wrap_c.ch", 64'(out_ch), 64'd0);

    // backpressure then drain+reload on the same edge
    drive(1'b1, 3'd0, 4'b1111, 1'b0);
    #1;
    held_d = out_data; held_c = out_ch;
    for (int k = 0; k < 3; k++) begin
      run_cycle("bp");
      check("bp.data_stable", 64'(out_data), 64'(held_d));
      check("bp.ch_stable", 64'(out_ch), 64'(held_c));
    end
    out_ready = 1'b1;
    run_cycle("bp_release");
    check("bp_release.ch", 64'(out_ch), 64'd1);

    // illegal select
    drive(1'b0, 3'd5, 4'b1111, 1'b1);
    run_cycle("illegal_drain");
    check("illegal.out_valid", 64'(out_valid), 64'd0);
    run_cycle("illegal_idle");

    // reset mid-operation, no clock edge required
    drive(1'b0, 3'd3, 4'b1111, 1'b0);
    run_cycle("mid_load");
    @(negedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst.out_valid", 64'(out_valid), 64'd0);
    check("async_rst.out_data", 64'(out_data), 64'd0);
    check("async_rst.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // random traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) set_ch(i, WIDTH'($urandom));
      drive(1'($urandom_range(0, 1)), SELW'($urandom_range(0, 5)),
            N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      run_cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

endmodule
